// File: rtl/sdio_host_pkg.sv
// Shared SDIO host definitions: receive-path state encoding and CRC16 constants.
package sdio_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_DATA       = 3'd2,
        ST_CRC        = 3'd3,
        ST_END        = 3'd4
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'h0000;

endpackage

// File: rtl/sdio_crc16_serial.sv
// Bit-serial CCITT CRC16 (x^16+x^12+x^5+1), one bit per enabled cycle.
// clr loads the init value and takes priority over en.
module sdio_crc16_serial
    import sdio_host_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        fb    = din ^ crc_q[15];
        crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) crc_q <= CRC16_INIT;
        else if (en)    crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/sdio_host_dat0_rx.sv
// Host DAT0 single-line block receiver: start bit, blk_len bytes MSB-first, CRC16, end bit.
// Define SDIO_HOST_RX_SYNC_EN to pass dat_in through a 2-flop synchronizer first.
module sdio_host_dat0_rx
    import sdio_host_pkg::*;
#(
    parameter int BLK_LEN_W = 11,
    parameter int TO_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dat_in,
    input  logic                 start,
    input  logic                 abort,
    input  logic [BLK_LEN_W-1:0] blk_len,
    input  logic [TO_W-1:0]      timeout_val,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_error,
    output logic                 end_error,
    output logic                 timeout
);

    localparam int                CNT_W   = BLK_LEN_W + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = {1'b1, {BLK_LEN_W{1'b0}}};
    localparam logic [TO_W-1:0]   TO_ONE  = 1;

    logic din_s;

`ifdef SDIO_HOST_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], dat_in};
    end
    assign din_s = sync_q[1];
`else
    assign din_s = dat_in;
`endif

    state_e           state_q;
    logic [CNT_W-1:0] len_q, byte_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [3:0]       crc_cnt_q;
    logic [6:0]       shift_q;
    logic [15:0]      cmp_q, crc_calc;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q, done_q, timeout_q, crc_error_q, end_error_q;
    logic             crc_clr, crc_en;

    assign crc_clr = (state_q == ST_IDLE) && start && !abort;
    assign crc_en  = (state_q == ST_DATA) && !abort;

    sdio_crc16_serial u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (din_s),
        .crc (crc_calc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            to_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            crc_cnt_q   <= '0;
            shift_q     <= '0;
            cmp_q       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            crc_error_q <= 1'b0;
            end_error_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: if (start) begin
                        state_q     <= ST_WAIT_START;
                        len_q       <= (blk_len == '0) ? CNT_MAX : {1'b0, blk_len};
                        crc_error_q <= 1'b0;
                        end_error_q <= 1'b0;
                        to_cnt_q    <= '0;
                        byte_cnt_q  <= '0;
                        bit_cnt_q   <= '0;
                        crc_cnt_q   <= '0;
                    end
                    ST_WAIT_START: begin
                        if (!din_s) begin
                            state_q <= ST_DATA;
                        end else if (timeout_val != '0 && to_cnt_q == timeout_val - TO_ONE) begin
                            timeout_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_ONE;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {shift_q[5:0], din_s};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_q  <= {shift_q, din_s};
                            rx_valid_q <= 1'b1;
                            byte_cnt_q <= byte_cnt_q + CNT_ONE;
                            if (byte_cnt_q + CNT_ONE == len_q) state_q <= ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        cmp_q     <= {cmp_q[14:0], din_s};
                        crc_cnt_q <= crc_cnt_q + 4'd1;
                        if (crc_cnt_q == 4'd15) state_q <= ST_END;
                    end
                    ST_END: begin
                        end_error_q <= ~din_s;
                        crc_error_q <= (cmp_q != crc_calc);
                        done_q      <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign crc_error = crc_error_q;
    assign end_error = end_error_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_sdio_host_dat0_rx.sv
// Directed bench for sdio_host_dat0_rx: full blocks, CRC/end-bit errors, timeout, abort, back-to-back.
module tb_sdio_host_dat0_rx;

    typedef byte unsigned bq_t[$];

    logic        clk = 1'b0;
    logic        rst, dat_in, start, abort;
    logic [10:0] blk_len;
    logic [15:0] timeout_val;
    logic [7:0]  rx_data;
    logic        rx_valid, busy, done, crc_error, end_error, timeout;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_to   = 0;
    byte unsigned rx_q[$];

    sdio_host_dat0_rx dut (
        .clk         (clk),
        .rst         (rst),
        .dat_in      (dat_in),
        .start       (start),
        .abort       (abort),
        .blk_len     (blk_len),
        .timeout_val (timeout_val),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .done        (done),
        .crc_error   (crc_error),
        .end_error   (end_error),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) rx_q.push_back(rx_data);
            if (done)     n_done++;
            if (timeout)  n_to++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input bq_t d);
        logic [15:0] c = 16'h0000;
        logic        fb;
        foreach (d[i])
            for (int b = 7; b >= 0; b--) begin
                fb = d[i][b] ^ c[15];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        return c;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dat_in = 1'b1;
        end
    endtask

    // nowait=1: caller is already at the negedge where start must be driven
    task automatic send_block(input logic [10:0] len, input bq_t d, input logic [15:0] c,
                              input logic eb, input bit nowait);
        if (!nowait) @(negedge clk);
        start = 1'b1; blk_len = len; dat_in = 1'b1;
        @(negedge clk); start = 1'b0; dat_in = 1'b1;
        @(negedge clk); dat_in = 1'b0;
        foreach (d[i])
            for (int b = 7; b >= 0; b--) begin
                @(negedge clk); dat_in = d[i][b];
            end
        for (int b = 15; b >= 0; b--) begin
            @(negedge clk); dat_in = c[b];
        end
        @(negedge clk); dat_in = eb;
    endtask

    task automatic check_rx(input string tag, input bq_t exp, input int base);
        int errs = 0;
        chk({tag, "_count"}, rx_q.size() - base, exp.size());
        foreach (exp[i])
            if (base + i >= rx_q.size() || rx_q[base + i] != exp[i]) errs++;
        chk({tag, "_data"}, errs, 0);
    endtask

    initial begin
        bq_t ff512, four, eight, inc2k, two;
        int  base, dbase, tbase, first;
        logic busy_at_to;

        rst = 1'b1; dat_in = 1'b1; start = 1'b0; abort = 1'b0;
        blk_len = '0; timeout_val = '0;
        for (int i = 0; i < 512; i++)  ff512.push_back(8'hFF);
        four  = '{8'h01, 8'h23, 8'h45, 8'h67};
        eight = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 2048; i++) inc2k.push_back(i[7:0]);
        two   = '{8'hAA, 8'h55};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", {rx_valid, busy, done, crc_error, end_error, timeout}, 6'b0);
        chk("reset_data", rx_data, 8'h00);

        // 512 x 0xFF with the known-good CRC
        base = rx_q.size(); dbase = n_done;
        send_block(11'd512, ff512, 16'h7FA1, 1'b1, 0);
        idle(3);
        check_rx("ff512", ff512, base);
        chk("ff512_done", n_done - dbase, 1);
        chk("ff512_crc_err", crc_error, 0);
        chk("ff512_end_err", end_error, 0);

        // same block, CRC bit 0 corrupted
        base = rx_q.size(); dbase = n_done;
        send_block(11'd512, ff512, 16'h7FA0, 1'b1, 0);
        idle(3);
        check_rx("badcrc", ff512, base);
        chk("badcrc_done", n_done - dbase, 1);
        chk("badcrc_crc_err", crc_error, 1);
        chk("badcrc_end_err", end_error, 0);

        // 4 bytes, good CRC, end bit 0
        base = rx_q.size(); dbase = n_done;
        send_block(11'd4, four, crc16(four), 1'b0, 0);
        idle(3);
        check_rx("endbit", four, base);
        chk("endbit_done", n_done - dbase, 1);
        chk("endbit_end_err", end_error, 1);
        chk("endbit_crc_err", crc_error, 0);

        // start-bit timeout
        timeout_val = 16'd100; dbase = n_done; tbase = n_to; first = -1; busy_at_to = 1'b1;
        @(negedge clk); start = 1'b1; blk_len = 11'd4; dat_in = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (timeout && first < 0) begin
                first = k;
                busy_at_to = busy;
            end
        end
        chk("to_cycle", first, 100);
        chk("to_busy", busy_at_to, 0);
        chk("to_pulses", n_to - tbase, 1);
        chk("to_no_done", n_done - dbase, 0);
        timeout_val = '0;

        // abort 3 bits into byte 2
        base = rx_q.size(); dbase = n_done;
        @(negedge clk); start = 1'b1; blk_len = 11'd8;
        @(negedge clk); start = 1'b0;
        @(negedge clk); dat_in = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            @(negedge clk); dat_in = eight[0][b];
        end
        for (int b = 7; b >= 5; b--) begin
            @(negedge clk); dat_in = eight[1][b];
        end
        @(negedge clk); dat_in = eight[1][4]; abort = 1'b1;
        @(negedge clk); abort = 1'b0; dat_in = 1'b1;
        chk("abort_busy", busy, 0);
        idle(20);
        chk("abort_count", rx_q.size() - base, 1);
        if (rx_q.size() > base) chk("abort_byte1", rx_q[base], 8'h11);
        chk("abort_no_done", n_done - dbase, 0);

        base = rx_q.size(); dbase = n_done;
        send_block(11'd8, eight, crc16(eight), 1'b1, 0);
        idle(3);
        check_rx("post_abort", eight, base);
        chk("post_abort_done", n_done - dbase, 1);
        chk("post_abort_crc_err", crc_error, 0);

        // 2048-byte block, then start in the done cycle
        base = rx_q.size(); dbase = n_done;
        send_block(11'd0, inc2k, crc16(inc2k), 1'b1, 0);
        @(negedge clk);
        chk("b2b_done_now", done, 1);
        chk("b2b_idle_now", busy, 0);
        chk("blk2k_crc_err", crc_error, 0);
        check_rx("blk2k", inc2k, base);
        base = rx_q.size();
        send_block(11'd2, two, crc16(two), 1'b1, 1);
        idle(3);
        check_rx("b2b", two, base);
        chk("b2b_done_total", n_done - dbase, 2);
        chk("b2b_crc_err", crc_error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdio_host_dat0_rx.md
Name: sdio_host_dat0_rx

Overview:
- Host-side DAT0 block receiver: the reading end for a card transmitting a data block with CRC16 on a single data line.
- Waits for the start bit, then deserializes blk_len bytes MSB-first and presents each as a one-cycle byte strobe.
- Checks the trailing CRC16 and end bit; reports status plus a start-bit timeout.
- Sits between the host DAT0 pad sampler and the host read FIFO/DMA; 1-bit bus mode only.

Parameters:
- BLK_LEN_W, 11, width of blk_len; value 0 means 2^BLK_LEN_W bytes (2048).
- TO_W, 16, width of timeout counter and timeout_val.

Ports:
- clk  in  1  sampling clock; one DAT0 bit per rising edge.
- rst  in  1  synchronous active-high reset.
- dat_in  in  1  sampled DAT0 line level.
- start  in  1  arm a block receive; ignored unless state is IDLE.
- abort  in  1  cancel any receive; wins over all other events.
- blk_len  in  BLK_LEN_W  block length in bytes; sampled when start is accepted.
- timeout_val  in  TO_W  start-bit wait limit in cycles; 0 disables timeout.
- rx_data  out  8  received byte; valid while rx_valid is high.
- rx_valid  out  1  one-cycle byte strobe.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the end bit is sampled.
- crc_error  out  1  CRC mismatch for the last block; held until the next accepted start.
- end_error  out  1  end bit sampled as 0; held until the next accepted start.
- timeout  out  1  one-cycle pulse when the start-bit wait expires.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters and CRC cleared.
- Uncertain-state handling: none needed; rst is the only reset.
- State machine:
  - IDLE: on start, go to WAIT_START. Latch blk_len. Clear crc_error, end_error, the timeout counter and the CRC register.
  - WAIT_START:
    - dat_in==0 goes to DATA; the start bit is not included in the CRC.
    - Otherwise the counter increments. If timeout_val!=0 and the counter equals timeout_val-1, pulse timeout and go to IDLE.
  - DATA:
    - Shift dat_in into an 8-bit shifter, MSB first, and feed the bit to the CRC.
    - After the 8th bit of a byte: rx_data and rx_valid are registered and appear the following cycle (1-cycle latency), and the byte counter increments.
    - After byte blk_len (0 => 2048), go to CRC.
  - CRC:
    - Shift 16 received bits MSB first into a compare register. The CRC generator is frozen.
    - After the 16th bit, go to END.
  - END:
    - Sample the end bit; end_error = ~dat_in.
    - crc_error = (received != computed), updated in the same cycle.
    - Pulse done the next cycle, then go to IDLE.
- CRC: CCITT CRC16, x^16+x^12+x^5+1, init 0x0000, serial, one bit per data cycle.
- abort: in any state, next state is IDLE. No done or timeout pulse. A pending rx_valid is suppressed. crc_error/end_error are unchanged.
- start while busy: ignored. start and abort in the same cycle: abort wins, start is dropped.
- Back-to-back blocks: start may be asserted in the cycle done pulses, because the state is already IDLE; it is accepted.
- Byte counter: BLK_LEN_W+1 bits, so 2048 fits without wrap.

Optional Feature:
- Macro: SDIO_HOST_RX_SYNC_EN.
- Defined: dat_in passes through a 2-flop synchronizer reset to 1 by rst. All sampling uses the synchronized bit, so latency from pad to rx_valid grows by 2 cycles. The timeout count is unchanged relative to the synchronized line.
- Undefined: dat_in is used directly as already-registered data.

Decomposition:
- Shared package sdio_host_pkg:
  - state encoding constants ST_IDLE, ST_WAIT_START, ST_DATA, ST_CRC, ST_END;
  - CRC16_POLY = 16'h1021;
  - CRC16_INIT = 16'h0000.
- Sub-module sdio_crc16_serial:
  - ports clk, rst, clr, en, din, crc[15:0];
  - reused later by the host transmit path.

Test Plan:
- blk_len=512, all data 0xFF, CRC 0x7FA1, end bit 1 -> 512 rx_valid strobes with rx_data=0xFF; done pulses; crc_error=0; end_error=0.
- Same block with CRC bit 0 flipped (0x7FA0) -> all 512 bytes delivered; done pulses; crc_error=1; end_error=0.
- blk_len=4, bytes 0x01 0x23 0x45 0x67, correct CRC, end bit 0 -> 4 strobes in order; end_error=1; crc_error=0.
- timeout_val=100, dat_in held 1 after start -> timeout pulses exactly 100 cycles after start is accepted; busy falls; done never pulses.
- abort 3 bits into byte 2 of a blk_len=8 block -> busy=0 next cycle; only byte 1 strobed; no done. A new start then receives a full 8-byte block correctly.
- blk_len=0 (2048 bytes, incrementing pattern), then start in the done cycle -> 2048 strobes; the second block is accepted with no idle gap.
